// File: rtl/da_cache.sv
// da_cache: DAC playback cache. Packs 16-bit host words into 48-bit entries
// held in a two-bank ping-pong RAM and plays them back as 24-bit samples,
// one per rising edge of spclk.
// Ports: clk/rst_n (async active-low); en (0 = flush); spclk (async sample
// clock level); wr/wdata host write strobe and word; ready (bank free);
// dac_data/dac_valid sample out; underrun/overflow sticky flags;
// level (number of full banks).
module da_cache #(
  parameter int USB_DATA_NBIT = 16,
  parameter int CHE_DATA_NBIT = 48,
  parameter int CHE_ADDR_NBIT = 9,
  parameter int DA_DATA_NBIT  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     spclk,
  input  logic                     wr,
  input  logic [USB_DATA_NBIT-1:0] wdata,
  output logic                     ready,
  output logic [DA_DATA_NBIT-1:0]  dac_data,
  output logic                     dac_valid,
  output logic                     underrun,
  output logic                     overflow,
  output logic [1:0]               level
);

  localparam int DEPTH = 2 ** CHE_ADDR_NBIT;
  localparam int SMP_NBIT = CHE_DATA_NBIT / 2;
  localparam logic [CHE_ADDR_NBIT-1:0] LAST = '1;

  // write side
  logic [CHE_DATA_NBIT-1:0] pack;
  logic [1:0]               pcnt;
  logic                     wr_pend;
  logic [CHE_ADDR_NBIT-1:0] waddr;
  logic                     wbank;

  // read side
  logic [2:0]               sp_sync;
  logic [CHE_ADDR_NBIT-1:0] raddr;
  logic                     rbank;
  logic                     half;
  logic                     rd_pend;
  logic                     rd_half;
  logic [CHE_DATA_NBIT-1:0] rd_q;

  logic [1:0]               full;
  logic                     en_q;

  logic [CHE_DATA_NBIT-1:0] mem [0:2*DEPTH-1];

  logic                accept, tick, rd_go, ram_we, wr_close, rd_close, close_arm;
  logic [1:0]          full_nxt;
  logic                wbank_nxt, ready_nxt;
  logic [SMP_NBIT-1:0] sample;

  assign accept    = wr & ready & en;
  assign tick      = en & (sp_sync[2:1] == 2'b01);
  assign rd_go     = tick & full[rbank];
  assign ram_we    = wr_pend & en;
  assign wr_close  = ram_we & (waddr == LAST);
  assign rd_close  = rd_go & half & (raddr == LAST);
  // third word of the last entry of a bank: the bank closes next cycle
  assign close_arm = accept & (pcnt == 2'd2) & (waddr == LAST);

  assign level  = {1'b0, full[0]} + {1'b0, full[1]};
  assign sample = rd_half ? rd_q[SMP_NBIT-1:0] : rd_q[CHE_DATA_NBIT-1:SMP_NBIT];

  // Writer and reader never own the same bank bit at once, so a close and a
  // drain in the same cycle both take effect.
  always_comb begin
    full_nxt  = full;
    wbank_nxt = wbank;
    if (wr_close) begin
      full_nxt[wbank] = 1'b1;
      wbank_nxt       = ~wbank;
    end
    if (rd_close)
      full_nxt[rbank] = 1'b0;
    if (!en) begin
      full_nxt  = '0;
      wbank_nxt = 1'b0;
    end
    // Look one write ahead: if a bank is about to close onto a full bank,
    // drop ready now so no word is taken in the closing cycle.
    ready_nxt = en & ~full_nxt[wbank_nxt] & ~(close_arm & full_nxt[~wbank_nxt]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack      <= '0;
      pcnt      <= '0;
      wr_pend   <= 1'b0;
      waddr     <= '0;
      wbank     <= 1'b0;
      sp_sync   <= '0;
      raddr     <= '0;
      rbank     <= 1'b0;
      half      <= 1'b0;
      rd_pend   <= 1'b0;
      rd_half   <= 1'b0;
      full      <= '0;
      en_q      <= 1'b0;
      ready     <= 1'b1;
      dac_data  <= '0;
      dac_valid <= 1'b0;
      underrun  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      sp_sync <= {sp_sync[1:0], spclk};
      en_q    <= en;
      full    <= full_nxt;
      wbank   <= wbank_nxt;
      ready   <= ready_nxt;
      if (!en) begin
        pcnt      <= '0;
        wr_pend   <= 1'b0;
        waddr     <= '0;
        raddr     <= '0;
        rbank     <= 1'b0;
        half      <= 1'b0;
        rd_pend   <= 1'b0;
        dac_valid <= 1'b0;
      end else begin
        // write side
        wr_pend <= accept & (pcnt == 2'd2);
        if (accept) begin
          pack <= {pack[CHE_DATA_NBIT-USB_DATA_NBIT-1:0], wdata};
          pcnt <= (pcnt == 2'd2) ? 2'd0 : pcnt + 2'd1;
        end
        if (ram_we)
          waddr <= wr_close ? '0 : waddr + 1'b1;

        // read side
        rd_pend <= rd_go;
        if (rd_go) begin
          rd_half <= half;
          half    <= ~half;
          if (half)
            raddr <= rd_close ? '0 : raddr + 1'b1;
          if (rd_close)
            rbank <= ~rbank;
        end
        dac_valid <= rd_pend;
        if (rd_pend)
          dac_data <= sample[SMP_NBIT-1 -: DA_DATA_NBIT];

        // sticky flags: cleared on the enable edge, a same-cycle event still sets
        if (!en_q) begin
          underrun <= 1'b0;
          overflow <= 1'b0;
        end
        if (tick && !full[rbank])
          underrun <= 1'b1;
        if (wr && !ready)
          overflow <= 1'b1;
      end
    end
  end

  // simple dual-port RAM, one-cycle read latency
  always_ff @(posedge clk) begin
    if (ram_we)
      mem[{wbank, waddr}] <= pack;
    if (rd_go)
      rd_q <= mem[{rbank, raddr}];
  end

endmodule

// File: tb/tb_da_cache.sv
// tb_da_cache: scoreboard bench for da_cache with a 4-entry-per-bank cache.
// Stimulus pushes expected samples (value and arrival cycle); a negedge
// monitor pops and compares whenever dac_valid is high.
module tb_da_cache;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        spclk = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] wdata = '0;
  logic        ready;
  logic [15:0] dac_data;
  logic        dac_valid;
  logic        underrun;
  logic        overflow;
  logic [1:0]  level;

  da_cache #(
    .USB_DATA_NBIT(16),
    .CHE_DATA_NBIT(48),
    .CHE_ADDR_NBIT(2),
    .DA_DATA_NBIT(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .spclk(spclk),
    .wr(wr),
    .wdata(wdata),
    .ready(ready),
    .dac_data(dac_data),
    .dac_valid(dac_valid),
    .underrun(underrun),
    .overflow(overflow),
    .level(level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int exp_data_q[$];
  int exp_cyc_q[$];
  int md, mc;

  logic [15:0] t2 [8] = '{16'h0001, 16'h0200, 16'h0004, 16'h0500,
                          16'h0007, 16'h0800, 16'h000A, 16'h0B00};

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // monitor: every dac_valid must match the oldest pending sample and cycle
  always @(negedge clk) begin
    if (rst_n && dac_valid) begin
      if (exp_data_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got data 0x%0h, expected no sample", dac_data);
      end else begin
        md = exp_data_q.pop_front();
        mc = exp_cyc_q.pop_front();
        check("dac_data", int'(dac_data), md);
        check("dac_valid_cycle", cyc, mc);
      end
    end
  end

  // lower sample's DAC slice spans the middle word's low byte and the last word's high byte
  function automatic logic [15:0] samp(input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] c, input bit h);
    return h ? {b[7:0], c[15:8]} : a;
  endfunction

  task automatic write_words(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      wr = 1'b1;
      wdata = base + 16'(i);
    end
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  // spclk rise in cycle c: sync tick in c+2, dac_valid in c+4
  task automatic sp_tick(input bit expv, input logic [15:0] d);
    @(posedge clk); #1;
    spclk = 1'b1;
    if (expv) begin
      exp_data_q.push_back(int'(d));
      exp_cyc_q.push_back(cyc + 4);
    end
    repeat (3) @(posedge clk);
    #1 spclk = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic play(input logic [15:0] base, input int n);
    for (int s = 0; s < n; s++) begin
      logic [15:0] a;
      a = base + 16'(3 * (s / 2));
      sp_tick(1'b1, samp(a, a + 16'd1, a + 16'd2, (s % 2) == 1));
    end
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", int'(ready), 1);
    check("rst_level", int'(level), 0);
    check("rst_dac_data", int'(dac_data), 0);
    check("rst_dac_valid", int'(dac_valid), 0);
    check("rst_underrun", int'(underrun), 0);
    check("rst_overflow", int'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    settle();

    // one bank in, eight samples out
    write_words(16'h0001, 12);
    settle();
    check("t2_level_full", int'(level), 1);
    check("t2_ready", int'(ready), 1);
    for (int i = 0; i < 8; i++) sp_tick(1'b1, t2[i]);
    settle();
    check("t2_level_empty", int'(level), 0);
    check("t2_underrun", int'(underrun), 0);

    // tick with nothing buffered
    sp_tick(1'b0, 16'h0000);
    settle();
    check("t4_underrun", int'(underrun), 1);
    check("t4_dac_hold", int'(dac_data), 16'h0B00);

    // fill both banks, then one word too many
    write_words(16'h1000, 24);
    settle();
    check("t3_ready_low", int'(ready), 0);
    check("t3_level_two", int'(level), 2);
    check("t3_overflow_clear", int'(overflow), 0);
    write_words(16'hDEAD, 1);
    settle();
    check("t3_overflow_set", int'(overflow), 1);
    play(16'h1000, 16);
    settle();
    check("t3_level_empty", int'(level), 0);
    check("t3_ready_back", int'(ready), 1);

    // flush mid-entry, then restart
    write_words(16'h4000, 7);
    @(posedge clk); #1;
    en = 1'b0;
    settle();
    check("t5_level_flush", int'(level), 0);
    check("t5_ready_flush", int'(ready), 0);
    check("t5_overflow_hold", int'(overflow), 1);
    check("t5_underrun_hold", int'(underrun), 1);
    en = 1'b1;
    settle();
    check("t5_underrun_cleared", int'(underrun), 0);
    check("t5_overflow_cleared", int'(overflow), 0);
    check("t5_ready_reenable", int'(ready), 1);
    write_words(16'h0100, 12);
    settle();
    check("t5_level", int'(level), 1);
    play(16'h0100, 8);
    settle();
    check("t5_level_empty", int'(level), 0);

    // bank close and bank drain on the same clock edge
    write_words(16'h2000, 12);
    play(16'h2000, 7);
    write_words(16'h3000, 11);
    settle();
    check("t6_level_before", int'(level), 1);
    @(posedge clk); #1;
    spclk = 1'b1;
    exp_data_q.push_back(int'(samp(16'h2009, 16'h200A, 16'h200B, 1'b1)));
    exp_cyc_q.push_back(cyc + 4);
    @(posedge clk); #1;
    wr = 1'b1;
    wdata = 16'h300B;
    @(posedge clk); #1;
    wr = 1'b0;
    @(posedge clk); #1;
    spclk = 1'b0;
    settle();
    check("t6_level_same", int'(level), 1);
    check("t6_no_underrun", int'(underrun), 0);
    check("t6_ready", int'(ready), 1);
    play(16'h3000, 8);
    settle();
    check("t6_level_empty", int'(level), 0);

    // asynchronous reset in the middle of a busy state
    write_words(16'h5000, 12);
    write_words(16'h6000, 12);
    write_words(16'hBEEF, 1);
    sp_tick(1'b1, 16'h5000);
    settle();
    check("t1_pre_level", int'(level), 2);
    check("t1_pre_overflow", int'(overflow), 1);
    check("t1_pre_dac", int'(dac_data), 16'h5000);
    #2 rst_n = 1'b0;
    #1;
    check("t1_ready", int'(ready), 1);
    check("t1_level", int'(level), 0);
    check("t1_dac_data", int'(dac_data), 0);
    check("t1_dac_valid", int'(dac_valid), 0);
    check("t1_underrun", int'(underrun), 0);
    check("t1_overflow", int'(overflow), 0);

    repeat (10) @(posedge clk);
    #1;
    check("pending_samples", exp_data_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
